// File: rtl/ctrl_fsm_multicycle_pkg.sv
// Shared types for the multi-cycle control unit: opcode/funct codes, ALU and branch encodings,
// FSM states and the decoded control bundle.
package ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_BLT   = 6'b000110;
   localparam logic [5:0] OP_BGT   = 6'b000111;
   localparam logic [5:0] OP_BLE   = 6'b010110;
   localparam logic [5:0] OP_BGE   = 6'b010111;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_JALR  = 6'b001001;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SLTU  = 6'b101011;

   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_ADD  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SUB  = 4'b0110,
      ALU_SLT  = 4'b0111,
      ALU_LUI  = 4'b1000,
      ALU_NOR  = 4'b1100,
      ALU_SLTU = 4'b1111
   } alu_op_e;

   typedef enum logic [2:0] {
      BR_EQ = 3'd0,
      BR_NE = 3'd1,
      BR_LT = 3'd2,
      BR_GT = 3'd3,
      BR_LE = 3'd4,
      BR_GE = 3'd5
   } branch_cond_e;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_e;

   typedef enum logic [3:0] {
      K_ALU     = 4'd0,
      K_BRANCH  = 4'd1,
      K_J       = 4'd2,
      K_JAL     = 4'd3,
      K_JR      = 4'd4,
      K_JALR    = 4'd5,
      K_LOAD    = 4'd6,
      K_STORE   = 4'd7,
      K_ILLEGAL = 4'd8
   } instr_kind_e;

   typedef struct packed {
      instr_kind_e  kind;
      alu_op_e      alu_op;
      logic         alu_src;
      branch_cond_e cond;
   } ctrl_t;

endpackage

// File: rtl/ctrl_fsm_multicycle_if.sv
// Instruction handshake, memory handshake and datapath control bundle of the control unit.
// master: the control unit; slave: the fetch/datapath side.
interface ctrl_fsm_multicycle_if import ctrl_pkg::*; #(
   parameter int REG_ADDR_W = 5
);
   logic                  instr_valid;
   logic [31:0]           instr;
   logic                  instr_ready;
   logic                  mem_ready;
   alu_op_e               alu_op;
   logic                  alu_src;
   logic [REG_ADDR_W-1:0] read_register_1;
   logic [REG_ADDR_W-1:0] read_register_2;
   logic [REG_ADDR_W-1:0] write_register;
   logic                  reg_write_enable;
   logic                  mem_to_reg;
   logic                  ram_read_enable;
   logic                  ram_write_enable;
   logic                  pc_increment;
   logic                  jump;
   logic                  jal;
   logic                  jr;
   logic                  branch;
   branch_cond_e          branch_cond;
   logic                  illegal_instr;
   logic                  mem_error;

   modport master (
      input  instr_valid, instr, mem_ready,
      output instr_ready, alu_op, alu_src, read_register_1, read_register_2, write_register,
             reg_write_enable, mem_to_reg, ram_read_enable, ram_write_enable, pc_increment,
             jump, jal, jr, branch, branch_cond, illegal_instr, mem_error
   );

   modport slave (
      output instr_valid, instr, mem_ready,
      input  instr_ready, alu_op, alu_src, read_register_1, read_register_2, write_register,
             reg_write_enable, mem_to_reg, ram_read_enable, ram_write_enable, pc_increment,
             jump, jal, jr, branch, branch_cond, illegal_instr, mem_error
   );
endinterface

// File: rtl/ctrl_fsm_multicycle_decode.sv
// Combinational instruction decoder: instruction word -> control bundle and register indices.
// CTRL_EXT_BRANCH_EN adds the BLT/BGT/BLE/BGE branch opcodes; otherwise they decode as illegal.
module ctrl_decode import ctrl_pkg::*; #(
   parameter int REG_ADDR_W = 5,
   parameter int LINK_REG   = 31
) (
   input  logic [31:0]           instr_i,
   output ctrl_t                 ctrl_o,
   output logic [REG_ADDR_W-1:0] rs_o,
   output logic [REG_ADDR_W-1:0] rt_o,
   output logic [REG_ADDR_W-1:0] wr_o
);
   logic [5:0]            opcode;
   logic [5:0]            funct;
   logic [REG_ADDR_W-1:0] rd;
   logic                  unused_shamt;

   assign opcode       = instr_i[31:26];
   assign funct        = instr_i[5:0];
   assign rs_o         = REG_ADDR_W'(instr_i[25:21]);
   assign rt_o         = REG_ADDR_W'(instr_i[20:16]);
   assign rd           = REG_ADDR_W'(instr_i[15:11]);
   assign unused_shamt = ^instr_i[10:6];

   always_comb begin
      ctrl_o = '{kind: K_ILLEGAL, alu_op: ALU_ADD, alu_src: 1'b0, cond: BR_EQ};
      wr_o   = rt_o;
      case (opcode)
         OP_RTYPE: begin
            wr_o        = rd;
            ctrl_o.kind = K_ALU;
            case (funct)
               FN_ADD:  ctrl_o.alu_op = ALU_ADD;
               FN_SUB:  ctrl_o.alu_op = ALU_SUB;
               FN_AND:  ctrl_o.alu_op = ALU_AND;
               FN_OR:   ctrl_o.alu_op = ALU_OR;
               FN_NOR:  ctrl_o.alu_op = ALU_NOR;
               FN_SLT:  ctrl_o.alu_op = ALU_SLT;
               FN_SLTU: ctrl_o.alu_op = ALU_SLTU;
               FN_JR:   ctrl_o.kind   = K_JR;
               FN_JALR: ctrl_o.kind   = K_JALR;
               default: ctrl_o.kind   = K_ILLEGAL;
            endcase
         end
         OP_ADDI:  ctrl_o = '{kind: K_ALU, alu_op: ALU_ADD,  alu_src: 1'b1, cond: BR_EQ};
         OP_SLTIU: ctrl_o = '{kind: K_ALU, alu_op: ALU_SLTU, alu_src: 1'b1, cond: BR_EQ};
         OP_ORI:   ctrl_o = '{kind: K_ALU, alu_op: ALU_OR,   alu_src: 1'b1, cond: BR_EQ};
         OP_XORI:  ctrl_o = '{kind: K_ALU, alu_op: ALU_XOR,  alu_src: 1'b1, cond: BR_EQ};
         OP_LUI:   ctrl_o = '{kind: K_ALU, alu_op: ALU_LUI,  alu_src: 1'b1, cond: BR_EQ};
         OP_LW:    ctrl_o = '{kind: K_LOAD,  alu_op: ALU_ADD, alu_src: 1'b1, cond: BR_EQ};
         OP_SW,
         OP_SB:    ctrl_o = '{kind: K_STORE, alu_op: ALU_ADD, alu_src: 1'b1, cond: BR_EQ};
         OP_BEQ:   ctrl_o = '{kind: K_BRANCH, alu_op: ALU_SUB, alu_src: 1'b0, cond: BR_EQ};
         OP_BNE:   ctrl_o = '{kind: K_BRANCH, alu_op: ALU_SUB, alu_src: 1'b0, cond: BR_NE};
`ifdef CTRL_EXT_BRANCH_EN
         OP_BLT:   ctrl_o = '{kind: K_BRANCH, alu_op: ALU_SUB, alu_src: 1'b0, cond: BR_LT};
         OP_BGT:   ctrl_o = '{kind: K_BRANCH, alu_op: ALU_SUB, alu_src: 1'b0, cond: BR_GT};
         OP_BLE:   ctrl_o = '{kind: K_BRANCH, alu_op: ALU_SUB, alu_src: 1'b0, cond: BR_LE};
         OP_BGE:   ctrl_o = '{kind: K_BRANCH, alu_op: ALU_SUB, alu_src: 1'b0, cond: BR_GE};
`endif
         OP_J:     ctrl_o.kind = K_J;
         OP_JAL: begin
            ctrl_o.kind = K_JAL;
            wr_o        = REG_ADDR_W'(LINK_REG);
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/ctrl_fsm_multicycle.sv
// Multi-cycle control unit: instruction handshake, decode register, EXEC/MEM/WB sequencing.
// Build option CTRL_EXT_BRANCH_EN (in ctrl_decode) enables the extended branch opcodes.
//
//   state  | meaning
//   IDLE   | instr_ready high, waiting for instr_valid
//   DECODE | latched instruction decoded, control registers loaded
//   EXEC   | one-cycle strobes for ALU/branch/jump; loads and stores continue to MEM
//   MEM    | RAM enable held, wait counter running until mem_ready or timeout
//   WB     | load writeback strobe
module ctrl_fsm_multicycle import ctrl_pkg::*; #(
   parameter int REG_ADDR_W   = 5,
   parameter int LINK_REG     = 31,
   parameter int MEM_WAIT_MAX = 15
) (
   input logic                  clk,
   input logic                  reset,
   ctrl_fsm_multicycle_if.master bus
);
   localparam int              CNT_W   = $clog2(MEM_WAIT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_WAIT_MAX);

   state_e                state_q;
   logic [31:0]           instr_q;
   instr_kind_e           kind_q;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   ctrl_t                 dec;
   logic [REG_ADDR_W-1:0] dec_rs, dec_rt, dec_wr;
   logic                  dec_wr_ok;

   logic                  instr_ready_q, alu_src_q;
   alu_op_e               alu_op_q;
   branch_cond_e          cond_q;
   logic [REG_ADDR_W-1:0] rs_q, rt_q, wr_q;
   logic                  reg_we_q, mem_to_reg_q, ram_re_q, ram_we_q, pc_inc_q;
   logic                  jump_q, jal_q, jr_q, branch_q, illegal_q, mem_error_q;

   ctrl_decode #(.REG_ADDR_W(REG_ADDR_W), .LINK_REG(LINK_REG)) u_decode (
      .instr_i (instr_q),
      .ctrl_o  (dec),
      .rs_o    (dec_rs),
      .rt_o    (dec_rt),
      .wr_o    (dec_wr)
   );

   assign cnt_d     = cnt_q + 1'b1;
   assign dec_wr_ok = (dec_wr != '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         instr_q       <= '0;
         kind_q        <= K_ALU;
         cnt_q         <= '0;
         instr_ready_q <= 1'b1;
         alu_op_q      <= ALU_AND;
         alu_src_q     <= 1'b0;
         cond_q        <= BR_EQ;
         rs_q          <= '0;
         rt_q          <= '0;
         wr_q          <= '0;
         reg_we_q      <= 1'b0;
         mem_to_reg_q  <= 1'b0;
         ram_re_q      <= 1'b0;
         ram_we_q      <= 1'b0;
         pc_inc_q      <= 1'b0;
         jump_q        <= 1'b0;
         jal_q         <= 1'b0;
         jr_q          <= 1'b0;
         branch_q      <= 1'b0;
         illegal_q     <= 1'b0;
         mem_error_q   <= 1'b0;
      end else begin
         reg_we_q     <= 1'b0;
         mem_to_reg_q <= 1'b0;
         pc_inc_q     <= 1'b0;
         jump_q       <= 1'b0;
         jal_q        <= 1'b0;
         jr_q         <= 1'b0;
         branch_q     <= 1'b0;
         illegal_q    <= 1'b0;
         mem_error_q  <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (bus.instr_valid) begin
                  instr_q       <= bus.instr;
                  instr_ready_q <= 1'b0;
                  state_q       <= S_DECODE;
               end
            end
            // Strobes are loaded here so they are visible for exactly the EXEC cycle.
            S_DECODE: begin
               alu_op_q  <= dec.alu_op;
               alu_src_q <= dec.alu_src;
               cond_q    <= dec.cond;
               rs_q      <= dec_rs;
               rt_q      <= dec_rt;
               wr_q      <= dec_wr;
               kind_q    <= dec.kind;
               state_q   <= S_EXEC;
               case (dec.kind)
                  K_ALU: begin
                     reg_we_q <= dec_wr_ok;
                     pc_inc_q <= 1'b1;
                  end
                  K_BRANCH: begin
                     branch_q <= 1'b1;
                     pc_inc_q <= 1'b1;
                  end
                  K_J: jump_q <= 1'b1;
                  K_JAL: begin
                     jump_q   <= 1'b1;
                     jal_q    <= 1'b1;
                     reg_we_q <= dec_wr_ok;
                  end
                  K_JR: jr_q <= 1'b1;
                  K_JALR: begin
                     jr_q     <= 1'b1;
                     jal_q    <= 1'b1;
                     reg_we_q <= dec_wr_ok;
                  end
                  K_ILLEGAL: begin
                     illegal_q <= 1'b1;
                     pc_inc_q  <= 1'b1;
                  end
                  default: ;
               endcase
            end
            S_EXEC: begin
               cnt_q <= '0;
               if (kind_q == K_LOAD) begin
                  ram_re_q <= 1'b1;
                  state_q  <= S_MEM;
               end else if (kind_q == K_STORE) begin
                  ram_we_q <= 1'b1;
                  state_q  <= S_MEM;
               end else begin
                  instr_ready_q <= 1'b1;
                  state_q       <= S_IDLE;
               end
            end
            // mem_ready is tested first so a response on the limit cycle still succeeds.
            S_MEM: begin
               cnt_q <= cnt_d;
               if (bus.mem_ready) begin
                  ram_re_q <= 1'b0;
                  ram_we_q <= 1'b0;
                  pc_inc_q <= 1'b1;
                  if (ram_re_q) begin
                     reg_we_q     <= (wr_q != '0);
                     mem_to_reg_q <= 1'b1;
                     state_q      <= S_WB;
                  end else begin
                     instr_ready_q <= 1'b1;
                     state_q       <= S_IDLE;
                  end
               end else if (cnt_d == CNT_MAX) begin
                  ram_re_q      <= 1'b0;
                  ram_we_q      <= 1'b0;
                  pc_inc_q      <= 1'b1;
                  mem_error_q   <= 1'b1;
                  instr_ready_q <= 1'b1;
                  state_q       <= S_IDLE;
               end
            end
            S_WB: begin
               instr_ready_q <= 1'b1;
               state_q       <= S_IDLE;
            end
            default: begin
               instr_ready_q <= 1'b1;
               state_q       <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.instr_ready      = instr_ready_q;
   assign bus.alu_op           = alu_op_q;
   assign bus.alu_src          = alu_src_q;
   assign bus.read_register_1  = rs_q;
   assign bus.read_register_2  = rt_q;
   assign bus.write_register   = wr_q;
   assign bus.reg_write_enable = reg_we_q;
   assign bus.mem_to_reg       = mem_to_reg_q;
   assign bus.ram_read_enable  = ram_re_q;
   assign bus.ram_write_enable = ram_we_q;
   assign bus.pc_increment     = pc_inc_q;
   assign bus.jump             = jump_q;
   assign bus.jal              = jal_q;
   assign bus.jr               = jr_q;
   assign bus.branch           = branch_q;
   assign bus.branch_cond      = cond_q;
   assign bus.illegal_instr    = illegal_q;
   assign bus.mem_error        = mem_error_q;
endmodule

// File: tb/tb_ctrl_fsm_multicycle.sv
// Directed bench for ctrl_fsm_multicycle: decode table for single-pass instructions plus
// hand-written memory, timeout and reset sequences.
module tb_ctrl_fsm_multicycle;
   import ctrl_pkg::*;

   localparam logic [10:0] S_RWE  = 11'h400;
   localparam logic [10:0] S_M2R  = 11'h200;
   localparam logic [10:0] S_RRE  = 11'h100;
   localparam logic [10:0] S_RWEN = 11'h080;
   localparam logic [10:0] S_PC   = 11'h040;
   localparam logic [10:0] S_J    = 11'h020;
   localparam logic [10:0] S_JAL  = 11'h010;
   localparam logic [10:0] S_JR   = 11'h008;
   localparam logic [10:0] S_BR   = 11'h004;
   localparam logic [10:0] S_ILL  = 11'h002;
   localparam logic [10:0] S_MERR = 11'h001;

   typedef struct packed {
      logic [31:0] instr;
      logic [10:0] strb;
      logic [3:0]  alu;
      logic        chk_alu;
      logic        alu_src;
      logic [4:0]  wr;
      logic        chk_wr;
      logic [2:0]  cond;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   failures = 0;
   vec_t vecs [22];

   ctrl_fsm_multicycle_if #(.REG_ADDR_W(5)) bus ();

   ctrl_fsm_multicycle #(.REG_ADDR_W(5), .LINK_REG(31), .MEM_WAIT_MAX(15)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [10:0] strobes();
      return {bus.reg_write_enable, bus.mem_to_reg, bus.ram_read_enable, bus.ram_write_enable,
              bus.pc_increment, bus.jump, bus.jal, bus.jr, bus.branch, bus.illegal_instr,
              bus.mem_error};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge of the EXEC cycle.
   task automatic issue(input string nm, input logic [31:0] ins);
      int w = 0;
      while (bus.instr_ready !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk({nm, "_ready_before"}, 32'(bus.instr_ready), 1);
      bus.instr       = ins;
      bus.instr_valid = 1'b1;
      @(posedge clk);
      #1 bus.instr_valid = 1'b0;
      bus.instr = 32'h0;
      @(negedge clk);
      chk({nm, "_decode_ready"}, 32'(bus.instr_ready), 0);
      chk({nm, "_decode_strb"}, 32'(strobes()), 0);
      @(negedge clk);
   endtask

   task automatic run_mem(input string nm, input logic [31:0] ins, input int ready_at,
                          input int exp_en, input logic [10:0] exp_post, input logic exp_idle);
      int   n_en = 0;
      logic load;
      load = (ins[31:26] == OP_LW);
      issue(nm, ins);
      chk({nm, "_exec_strb"}, 32'(strobes()), 0);
      chk({nm, "_alu_op"}, 32'(bus.alu_op), 32'(4'b0010));
      chk({nm, "_alu_src"}, 32'(bus.alu_src), 1);
      if (load) chk({nm, "_wr_reg"}, 32'(bus.write_register), 32'(ins[20:16]));
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1 bus.mem_ready = 1'b0;
         @(negedge clk);
         if ((load ? bus.ram_read_enable : bus.ram_write_enable) !== 1'b1) break;
         n_en++;
         if (n_en == ready_at) bus.mem_ready = 1'b1;
      end
      chk({nm, "_enable_cycles"}, 32'(n_en), 32'(exp_en));
      chk({nm, "_post_strb"}, 32'(strobes()), 32'(exp_post));
      chk({nm, "_post_ready"}, 32'(bus.instr_ready), 32'(exp_idle));
      @(negedge clk);
      chk({nm, "_idle_ready"}, 32'(bus.instr_ready), 1);
      chk({nm, "_idle_strb"}, 32'(strobes()), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.instr_valid = 1'b0;
      bus.instr       = 32'h0;
      bus.mem_ready   = 1'b0;

      //           instr         strobes              alu     ca   src  wr     cw   cond
      vecs[0]  = '{32'h00222020, S_RWE | S_PC,        4'b0010, 1'b1, 1'b0, 5'd4,  1'b1, 3'd0};
      vecs[1]  = '{32'h00221822, S_RWE | S_PC,        4'b0110, 1'b1, 1'b0, 5'd3,  1'b1, 3'd0};
      vecs[2]  = '{32'h00C72824, S_RWE | S_PC,        4'b0000, 1'b1, 1'b0, 5'd5,  1'b1, 3'd0};
      vecs[3]  = '{32'h00225825, S_RWE | S_PC,        4'b0011, 1'b1, 1'b0, 5'd11, 1'b1, 3'd0};
      vecs[4]  = '{32'h00224027, S_RWE | S_PC,        4'b1100, 1'b1, 1'b0, 5'd8,  1'b1, 3'd0};
      vecs[5]  = '{32'h0022482A, S_RWE | S_PC,        4'b0111, 1'b1, 1'b0, 5'd9,  1'b1, 3'd0};
      vecs[6]  = '{32'h0022502B, S_RWE | S_PC,        4'b1111, 1'b1, 1'b0, 5'd10, 1'b1, 3'd0};
      vecs[7]  = '{32'h20270005, S_RWE | S_PC,        4'b0010, 1'b1, 1'b1, 5'd7,  1'b1, 3'd0};
      vecs[8]  = '{32'h34270005, S_RWE | S_PC,        4'b0011, 1'b1, 1'b1, 5'd7,  1'b1, 3'd0};
      vecs[9]  = '{32'h38270005, S_RWE | S_PC,        4'b0100, 1'b1, 1'b1, 5'd7,  1'b1, 3'd0};
      vecs[10] = '{32'h2C270005, S_RWE | S_PC,        4'b1111, 1'b1, 1'b1, 5'd7,  1'b1, 3'd0};
      vecs[11] = '{32'h3C070005, S_RWE | S_PC,        4'b1000, 1'b1, 1'b1, 5'd7,  1'b1, 3'd0};
      vecs[12] = '{32'h20000005, S_PC,                4'b0010, 1'b1, 1'b1, 5'd0,  1'b1, 3'd0};
      vecs[13] = '{32'h10850003, S_BR | S_PC,         4'b0110, 1'b1, 1'b0, 5'd0,  1'b0, 3'd0};
      vecs[14] = '{32'h14850003, S_BR | S_PC,         4'b0110, 1'b1, 1'b0, 5'd0,  1'b0, 3'd1};
      vecs[15] = '{32'h08000010, S_J,                 4'b0000, 1'b0, 1'b0, 5'd0,  1'b0, 3'd0};
      vecs[16] = '{32'h0C000010, S_J | S_JAL | S_RWE, 4'b0000, 1'b0, 1'b0, 5'd31, 1'b1, 3'd0};
      vecs[17] = '{32'h03E00008, S_JR,                4'b0000, 1'b0, 1'b0, 5'd0,  1'b0, 3'd0};
      vecs[18] = '{32'h00601009, S_JR | S_JAL | S_RWE, 4'b0000, 1'b0, 1'b0, 5'd2, 1'b1, 3'd0};
      vecs[19] = '{32'hFC000000, S_ILL | S_PC,        4'b0000, 1'b0, 1'b0, 5'd0,  1'b0, 3'd0};
      vecs[20] = '{32'h0022203F, S_ILL | S_PC,        4'b0000, 1'b0, 1'b0, 5'd0,  1'b0, 3'd0};
`ifdef CTRL_EXT_BRANCH_EN
      vecs[21] = '{32'h18850003, S_BR | S_PC,         4'b0110, 1'b1, 1'b0, 5'd0,  1'b0, 3'd2};
`else
      vecs[21] = '{32'h18850003, S_ILL | S_PC,        4'b0000, 1'b0, 1'b0, 5'd0,  1'b0, 3'd0};
`endif

      repeat (2) @(negedge clk);
      chk("reset_ready", 32'(bus.instr_ready), 1);
      chk("reset_strb", 32'(strobes()), 0);
      chk("reset_alu_op", 32'(bus.alu_op), 0);
      chk("reset_wr_reg", 32'(bus.write_register), 0);
      chk("reset_cond", 32'(bus.branch_cond), 0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 22; i++) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         issue(nm, vecs[i].instr);
         chk({nm, "_exec_strb"}, 32'(strobes()), 32'(vecs[i].strb));
         chk({nm, "_rs"}, 32'(bus.read_register_1), 32'(vecs[i].instr[25:21]));
         chk({nm, "_rt"}, 32'(bus.read_register_2), 32'(vecs[i].instr[20:16]));
         if (vecs[i].chk_alu) begin
            chk({nm, "_alu_op"}, 32'(bus.alu_op), 32'(vecs[i].alu));
            chk({nm, "_alu_src"}, 32'(bus.alu_src), 32'(vecs[i].alu_src));
         end
         if (vecs[i].chk_wr) chk({nm, "_wr_reg"}, 32'(bus.write_register), 32'(vecs[i].wr));
         if ((vecs[i].strb & S_BR) != 0)
            chk({nm, "_cond"}, 32'(bus.branch_cond), 32'(vecs[i].cond));
         @(negedge clk);
         chk({nm, "_t3_ready"}, 32'(bus.instr_ready), 1);
         chk({nm, "_t3_strb"}, 32'(strobes()), 0);
      end

      run_mem("lw_ok",   32'h8C040001, 3,  3,  S_RWE | S_M2R | S_PC, 1'b0);
      run_mem("lw_r0",   32'h8C000001, 2,  2,  S_M2R | S_PC,         1'b0);
      run_mem("sw_tmo",  32'hAC050000, 0,  15, S_MERR | S_PC,        1'b1);
      run_mem("sw_limit", 32'hAC050000, 15, 15, S_PC,                1'b1);
      run_mem("sb_fast", 32'hA0050000, 1,  1,  S_PC,                 1'b1);

      // Reset asserted in the middle of a load's MEM phase.
      issue("lw_rst", 32'h8C040001);
      @(negedge clk);
      @(negedge clk);
      chk("lw_rst_in_mem", 32'(bus.ram_read_enable), 1);
      reset = 1'b0;
      #1;
      chk("rst_async_strb", 32'(strobes()), 0);
      chk("rst_async_ready", 32'(bus.instr_ready), 1);
      chk("rst_async_wr_reg", 32'(bus.write_register), 0);
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("rst_after%0d_strb", c), 32'(strobes()), 0);
         chk($sformatf("rst_after%0d_ready", c), 32'(bus.instr_ready), 1);
      end
      issue("add_after_rst", 32'h00222020);
      chk("add_after_rst_strb", 32'(strobes()), 32'(S_RWE | S_PC));
      chk("add_after_rst_wr", 32'(bus.write_register), 4);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
